// File: rtl/byte_serializer.sv
// byte_serializer: buffers parallel words in a small FIFO and shifts them
// out one bit per clock, gap-free across word boundaries.
module byte_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     dout,
    output logic                     dout_valid,
    output logic                     frame_start,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    idx;

    logic             full;
    logic             push;
    logic             pop;
    logic             last_bit;
    logic             shifting;
    logic [WIDTH-1:0] head;

    // First bit to transmit from a word, honouring the configured bit order.
    function automatic logic lead(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit consumed, so the next bit becomes the lead.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Handshake and pop decisions, all derived from registered state.
    assign full       = (count == CW'(DEPTH));
    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign last_bit   = (idx == IW'(WIDTH - 1));
    assign shifting   = (state == SHIFT) && !last_bit;
    assign pop        = (count != '0) && ((state == IDLE) || ((state == SHIFT) && last_bit));
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    // FIFO storage; contents need no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Shifter FSM: load on pop (from IDLE or on the last bit), else shift or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pop) begin
            state       <= SHIFT;
            shreg       <= advance(head);
            idx         <= '0;
            dout        <= lead(head);
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
        end else if (shifting) begin
            state       <= SHIFT;
            shreg       <= advance(shreg);
            idx         <= idx + IW'(1);
            dout        <= lead(shreg);
            dout_valid  <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= IDLE;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: scoreboard of expected bit stream
// plus directed checks for reset, latency, contiguity, fill and bit order.
module tb_byte_serializer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       dout;
    logic       dout_valid;
    logic       frame_start;
    logic [2:0] fifo_count;

    logic [7:0] l_data;
    logic       l_valid;
    logic       l_ready;
    logic       l_dout;
    logic       l_dv;
    logic       l_fs;
    logic [2:0] l_count;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    bit exp_fs[$];
    bit rst_seen;
    logic [2:0] prev_cnt;

    byte_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
        .frame_start(frame_start), .fifo_count(fifo_count)
    );

    byte_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid),
        .in_ready(l_ready), .dout(l_dout), .dout_valid(l_dv),
        .frame_start(l_fs), .fifo_count(l_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word becomes WIDTH expected bits, MSB first.
    always @(posedge clk) begin
        rst_seen <= rst;
        if (rst) begin
            exp_q.delete();
            exp_fs.delete();
        end else if (in_valid && in_ready) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                exp_q.push_back(in_data[WIDTH-1-i]);
                exp_fs.push_back(i == 0);
            end
        end
    end

    // Monitor: pops the scoreboard on every valid bit, checks idle outputs otherwise.
    always begin
        @(negedge clk);
        #1;
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit: got dout=%0b with empty scoreboard at %0t", dout, $time);
            end else begin
                bit eb;
                bit ef;
                eb = exp_q.pop_front();
                ef = exp_fs.pop_front();
                chk("dout_bit", 32'(dout), 32'(eb));
                chk("frame_start_bit", 32'(frame_start), 32'(ef));
            end
        end else begin
            chk("idle_dout", 32'(dout), 32'd0);
            chk("idle_frame_start", 32'(frame_start), 32'd0);
        end
        chk("in_ready_rule", 32'(in_ready), 32'(!rst && (int'(fifo_count) != int'(DEPTH))));
        if (!rst_seen && !$isunknown(prev_cnt)) begin
            int d;
            d = int'(fifo_count) - int'(prev_cnt);
            chk("count_step", 32'(d >= -1 && d <= 1), 32'd1);
        end
        prev_cnt = fifo_count;
    end

    // Present a word (called at a negedge) and hold it until accepted.
    task automatic send(input logic [7:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 100) begin
            @(posedge clk);
            acc = in_ready;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word 0x%0h not accepted, required within 100 cycles", d);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the next run of valid bits and record it in transmit order.
    task automatic capture(output logic [63:0] bits, output logic [63:0] fsv,
                           output int len, output int wn);
        bits = '0;
        fsv  = '0;
        len  = 0;
        wn   = 0;
        while (!dout_valid && wn < 50) begin
            @(negedge clk);
            wn++;
        end
        while (dout_valid && len < 64) begin
            bits = {bits[62:0], dout};
            fsv  = {fsv[62:0], frame_start};
            len++;
            @(negedge clk);
        end
    endtask

    // Let all scoreboard bits drain, bounded.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [63:0] bits;
    logic [63:0] fsv;
    int          len;
    int          wn;
    int          maxc;
    bit          saw_full;
    logic [7:0]  lbits;
    logic [7:0]  lfs;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        l_valid = 1'b0;
        l_data = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Single word with latency check
        send(8'hD0);
        chk("single_gap_cycle", 32'(dout_valid), 32'd0);
        capture(bits, fsv, len, wn);
        chk("single_latency", 32'(wn), 32'd1);
        chk("single_len", 32'(len), 32'd8);
        chk("single_bits", 32'(bits[7:0]), 32'hD0);
        chk("single_fs", 32'(fsv[7:0]), 32'h80);
        drain();

        // Back-to-back words stream without a gap
        fork
            capture(bits, fsv, len, wn);
            begin
                send(8'hDD);
                send(8'h0D);
            end
        join
        chk("b2b_len", 32'(len), 32'd16);
        chk("b2b_bits", 32'(bits[15:0]), 32'b1101110100001101);
        chk("b2b_fs", 32'(fsv[15:0]), 32'b1000000010000000);
        drain();

        // Fill: six words back to back into a 4-deep FIFO
        maxc = 0;
        saw_full = 1'b0;
        fork
            capture(bits, fsv, len, wn);
            begin
                for (int i = 0; i < 6; i++) send(8'($urandom));
            end
            begin
                for (int i = 0; i < 70; i++) begin
                    @(negedge clk);
                    #1;
                    if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
                    if (fifo_count == 3'd4 && in_valid && !in_ready) saw_full = 1'b1;
                end
            end
        join
        chk("fill_max_count", 32'(maxc), 32'd4);
        chk("fill_ready_low", 32'(saw_full), 32'd1);
        chk("fill_len", 32'(len), 32'd48);
        drain();

        // LSB-first instance
        @(negedge clk);
        l_valid = 1'b1;
        l_data  = 8'h0B;
        @(posedge clk);
        chk("lsb_ready", 32'(l_ready), 32'd1);
        @(negedge clk);
        l_valid = 1'b0;
        wn = 0;
        while (!l_dv && wn < 50) begin
            @(negedge clk);
            wn++;
        end
        chk("lsb_latency", 32'(wn), 32'd1);
        lbits = '0;
        lfs = '0;
        for (int i = 0; i < 8; i++) begin
            lbits = {lbits[6:0], l_dout & l_dv};
            lfs   = {lfs[6:0], l_fs};
            @(negedge clk);
        end
        chk("lsb_bits", 32'(lbits), 32'hD0);
        chk("lsb_fs", 32'(lfs), 32'h80);
        chk("lsb_end", 32'(l_dv), 32'd0);

        // Randomized traffic with random gaps
        for (int w = 0; w < 40; w++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            send(8'($urandom));
        end
        drain();

        // Reset in the middle of the first of three buffered words
        fork
            begin
                send(8'($urandom));
                send(8'($urandom));
                send(8'($urandom));
            end
            begin
                wn = 0;
                while (!(dout_valid && frame_start) && wn < 100) begin
                    @(negedge clk);
                    wn++;
                end
                repeat (3) @(negedge clk);
                chk("mid_bit3_valid", 32'(dout_valid), 32'd1);
                rst = 1'b1;
            end
        join
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        #1;
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_frame_start", 32'(frame_start), 32'd0);
        chk("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        send(8'hD0);
        chk("post_rst_gap_cycle", 32'(dout_valid), 32'd0);
        capture(bits, fsv, len, wn);
        chk("post_rst_latency", 32'(wn), 32'd1);
        chk("post_rst_len", 32'(len), 32'd8);
        chk("post_rst_bits", 32'(bits[7:0]), 32'hD0);
        repeat (30) @(negedge clk);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
